dac_sample_streamer: RTL
========================

DAC_SAMPLE_STREAMER -- requirements
Module: dac_sample_streamer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16; sample FIFO depth, power of two, 4..256.
REQ-002 Parameter DIV_W, default 16; width of the rate-divider input.
REQ-003 sys_clk_pin  in  1  single system clock; all logic on its rising edge.
REQ-004 sys_rst_pin  in  1  reset, synchronous, active-low.
REQ-005 enable  in  1  streaming enable from the bus control register.
REQ-006 div_val  in  DIV_W  half-period of DCLKIO minus one, in sys_clk cycles.
REQ-007 fmt_twos  in  1  1 = two's-complement samples, 0 = offset binary.
REQ-008 pwrdn_req  in  1  request DAC power-down.
REQ-009 wr_valid  in  1  upstream sample write strobe.
REQ-010 wr_data  in  10  upstream sample.
REQ-011 wr_ready  out  1  FIFO can accept a sample this cycle.
REQ-012 underrun_clr  in  1  clears the underrun flag.
REQ-013 underrun  out  1  sticky underrun flag.
REQ-014 fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 S_Data_pin  out  [0:9]  DAC data bus, bit 0 = MSB.
REQ-016 S_DCLKIO_pin  out  1  DAC sample clock; DAC latches on rising edge.
REQ-017 S_Clkout_pin  out  1  copy of S_DCLKIO_pin.
REQ-018 S_PinMD_pin, S_ClkMD_pin  out  1 each  constant 1, constant 0.
REQ-019 S_Format_pin  out  1  registered fmt_twos.
REQ-020 S_PWRDN_pin  out  1  DAC power-down, active-high.

Function
REQ-021 FSM states IDLE, RUN, PWRDN; encoding internal.
REQ-022 IDLE->RUN when enable=1 and pwrdn_req=0; RUN->IDLE when enable=0; any state->PWRDN when pwrdn_req=1; PWRDN->IDLE when pwrdn_req=0.
REQ-023 Divider counts 0..D, D = max(div_val,1); tick on count==D, then wraps to 0; counter held at 0 outside RUN.
REQ-024 Each tick in RUN toggles S_DCLKIO_pin; sample period = 2*(D+1) cycles.
REQ-025 On a tick driving DCLKIO 1->0: pop FIFO head and register it onto S_Data_pin in the same edge.
REQ-026 Pop on empty FIFO: S_Data_pin holds its value, underrun set.
REQ-027 Push when wr_valid=1 and wr_ready=1; wr_ready = (fifo_level<FIFO_DEPTH) and state!=PWRDN.
REQ-028 Simultaneous push and pop: both take effect, fifo_level unchanged; on empty, pop underruns and push is stored.
REQ-029 Write while full: sample dropped, no flag; upstream bears the responsibility.
REQ-030 Latency: sample pushed into empty FIFO in RUN appears on S_Data_pin at the next falling tick.
REQ-031 RUN->IDLE: DCLKIO forced 0 next cycle; FIFO and S_Data_pin retained.
REQ-032 Entry into PWRDN flushes FIFO; S_PWRDN_pin=1, DCLKIO=0, S_Data_pin=midscale (10'h200 offset binary, 10'h000 two's-complement).
REQ-033 underrun_clr and a new underrun in the same cycle: underrun stays 1.
REQ-034 div_val changes take effect at the next wrap only.

Reset
REQ-035 While sys_rst_pin=0 at a clock edge: state IDLE, FIFO empty, fifo_level 0, wr_ready 0, underrun 0, counter 0.
REQ-036 Reset outputs: S_Data_pin 10'h200, S_DCLKIO_pin 0, S_Clkout_pin 0, S_PWRDN_pin 1, S_Format_pin 0.
REQ-037 Reset asserted mid-operation aborts the current period immediately; no partial DCLKIO pulse after release.
REQ-038 wr_ready rises the first cycle after sys_rst_pin returns to 1.

Structure
REQ-039 Shared package holds FSM state typedef, DAC_W=10, midscale constants, fixed PinMD/ClkMD values.
REQ-040 FIFO is one sub-module, dac_sample_fifo (synchronous, first-word registered read, level output).
REQ-041 Divider, FSM and pin registers live in the top module; all pin outputs registered.

Verification
REQ-042 Reset, then idle: S_Data_pin=10'h200, S_PWRDN_pin=1, wr_ready=1 one cycle after release.
REQ-043 div_val=4, enable=1, push 10'h001,10'h002,10'h003: DCLKIO period 10 cycles; values appear in order on successive falling edges.
REQ-044 Push 16 samples with enable=0: fifo_level=16, wr_ready=0; 17th write dropped, level stays 16.
REQ-045 RUN with empty FIFO for one falling tick: underrun=1, S_Data_pin unchanged; underrun_clr pulse -> 0.
REQ-046 pwrdn_req=1 with fifo_level=5, fmt_twos=1: next cycle fifo_level=0, S_PWRDN_pin=1, S_Data_pin=10'h000, DCLKIO=0.
REQ-047 sys_rst_pin=0 mid-RUN with DCLKIO=1: next edge DCLKIO=0, FIFO empty, outputs at reset values.

Source files
------------

// File: rtl/dac_sample_streamer_pkg.sv
// ---------------------------------------------------------------------------
// dac_sample_streamer_pkg
// Shared definitions for the DAC sample streamer: the streaming FSM state
// type, the DAC word width, the midscale codes for both sample formats and
// the fixed strap values driven onto the DAC mode pins.
// No ports (package).
// ---------------------------------------------------------------------------
package dac_sample_streamer_pkg;

    localparam int DAC_W = 10;

    localparam logic [DAC_W-1:0] MIDSCALE_OFFSET = 10'h200;
    localparam logic [DAC_W-1:0] MIDSCALE_TWOS   = 10'h000;

    localparam logic PINMD_VAL = 1'b1;
    localparam logic CLKMD_VAL = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PWRDN = 2'd2
    } streamState_e;

    // Zero-amplitude code for the currently selected sample format.
    function automatic logic [DAC_W-1:0] midscale(input logic fmtTwos);
        return fmtTwos ? MIDSCALE_TWOS : MIDSCALE_OFFSET;
    endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// ---------------------------------------------------------------------------
// dac_sample_fifo
// Synchronous sample FIFO with the head word always presented on head_o
// straight from the storage registers, so the consumer can capture it on
// the same edge that pops it.
// Ports:
//   clk_i        clock, rising edge
//   rstN_i       synchronous active-low reset (empties the FIFO)
//   flush_i      synchronous flush, same effect as reset
//   push_i       write strobe (ignored when full)
//   pushData_i   sample to write
//   pop_i        read strobe (ignored when empty)
//   head_o       oldest stored sample
//   empty_o      no samples stored
//   full_o       DEPTH samples stored
//   level_o      current occupancy
// ---------------------------------------------------------------------------
module dac_sample_fifo
    import dac_sample_streamer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rstN_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [DAC_W-1:0]        pushData_i,
    input  logic                    pop_i,
    output logic [DAC_W-1:0]        head_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DAC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [AW:0]      level_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];
    assign level_o = level_q;

    // Pointers wrap naturally because DEPTH is a power of two; a push and a
    // pop in the same cycle leave the level untouched.
    always_ff @(posedge clk_i) begin
        if (!rstN_i || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (doPush && !doPop) begin
                level_q <= level_q + (AW+1)'(1);
            end else if (doPop && !doPush) begin
                level_q <= level_q - (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; stale words are never visible while empty.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/dac_sample_streamer.sv
// ---------------------------------------------------------------------------
// dac_sample_streamer
// Streams buffered 10-bit samples to a parallel DAC. A programmable divider
// produces DCLKIO; each falling DCLKIO transition pops the next sample onto
// the data bus so it is stable for the DAC's rising-edge latch.
// Ports:
//   sys_clk_pin / sys_rst_pin   clock, synchronous active-low reset
//   enable, pwrdn_req           streaming enable and power-down request
//   div_val                     DCLKIO half-period minus one (0 treated as 1)
//   fmt_twos                    1 = two's-complement, 0 = offset binary
//   wr_valid/wr_data/wr_ready   upstream sample write port
//   underrun/underrun_clr       sticky underrun flag and its clear
//   fifo_level                  current FIFO occupancy
//   S_*_pin                     registered DAC pins
// ---------------------------------------------------------------------------
module dac_sample_streamer
    import dac_sample_streamer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                         sys_clk_pin,
    input  logic                         sys_rst_pin,
    input  logic                         enable,
    input  logic [DIV_W-1:0]             div_val,
    input  logic                         fmt_twos,
    input  logic                         pwrdn_req,
    input  logic                         wr_valid,
    input  logic [DAC_W-1:0]             wr_data,
    output logic                         wr_ready,
    input  logic                         underrun_clr,
    output logic                         underrun,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic [0:DAC_W-1]             S_Data_pin,
    output logic                         S_DCLKIO_pin,
    output logic                         S_Clkout_pin,
    output logic                         S_PinMD_pin,
    output logic                         S_ClkMD_pin,
    output logic                         S_Format_pin,
    output logic                         S_PWRDN_pin
);

    streamState_e     state_q, state_d;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [DIV_W-1:0] divTop_q, divTop_d;
    logic             dclk_q, dclk_d;
    logic [DAC_W-1:0] data_q, data_d;
    logic             underrun_q, underrun_d;
    logic             pwrdn_q, pwrdn_d;
    logic             format_q, format_d;
    logic             rstDone_q;

    logic [DIV_W-1:0] divTopNew;
    logic             stayRun;
    logic             divTick;
    logic             fallTick;
    logic             fifoPush;
    logic             fifoFlush;
    logic [DAC_W-1:0] fifoHead;
    logic             fifoEmpty;
    logic             fifoFull;

    assign divTopNew = (div_val == '0) ? DIV_W'(1) : div_val;
    // Ticks only count while RUN persists; a tick on the cycle RUN is left is
    // discarded so DCLKIO simply parks low.
    assign stayRun   = (state_q == RUN) && (state_d == RUN);
    assign divTick   = stayRun && (divCnt_q == divTop_q);
    assign fallTick  = divTick && dclk_q;

    assign wr_ready  = rstDone_q && !fifoFull && (state_q != PWRDN);
    assign fifoPush  = wr_valid && wr_ready;
    assign fifoFlush = (state_d == PWRDN);

    dac_sample_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (sys_clk_pin),
        .rstN_i     (sys_rst_pin),
        .flush_i    (fifoFlush),
        .push_i     (fifoPush),
        .pushData_i (wr_data),
        .pop_i      (fallTick),
        .head_o     (fifoHead),
        .empty_o    (fifoEmpty),
        .full_o     (fifoFull),
        .level_o    (fifo_level)
    );

    // Power-down request overrides everything; otherwise enable moves
    // between IDLE and RUN, and PWRDN always passes back through IDLE.
    always_comb begin
        state_d = state_q;
        if (pwrdn_req) begin
            state_d = PWRDN;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_d = RUN;
                RUN:     if (!enable) state_d = IDLE;
                PWRDN:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The divider period is reloaded only on a wrap or while not running,
    // so a div_val change never shortens or stretches a half-period in
    // flight.
    always_comb begin
        divCnt_d   = '0;
        divTop_d   = divTopNew;
        dclk_d     = dclk_q;
        data_d     = data_q;
        pwrdn_d    = (state_d != RUN);
        format_d   = fmt_twos;
        underrun_d = (underrun_q && !underrun_clr) || (fallTick && fifoEmpty);

        if (stayRun && !divTick) begin
            divCnt_d = divCnt_q + DIV_W'(1);
            divTop_d = divTop_q;
        end

        if (state_d == PWRDN) begin
            dclk_d = 1'b0;
            data_d = midscale(fmt_twos);
        end else if (state_d != RUN) begin
            dclk_d = 1'b0;
        end else if (divTick) begin
            dclk_d = !dclk_q;
            if (dclk_q && !fifoEmpty) begin
                data_d = fifoHead;
            end
        end
    end

    // rstDone_q holds off wr_ready for exactly the reset cycles.
    always_ff @(posedge sys_clk_pin) begin
        if (!sys_rst_pin) begin
            state_q    <= IDLE;
            divCnt_q   <= '0;
            divTop_q   <= DIV_W'(1);
            dclk_q     <= 1'b0;
            data_q     <= MIDSCALE_OFFSET;
            underrun_q <= 1'b0;
            pwrdn_q    <= 1'b1;
            format_q   <= 1'b0;
            rstDone_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            divTop_q   <= divTop_d;
            dclk_q     <= dclk_d;
            data_q     <= data_d;
            underrun_q <= underrun_d;
            pwrdn_q    <= pwrdn_d;
            format_q   <= format_d;
            rstDone_q  <= 1'b1;
        end
    end

    // data_q[DAC_W-1] lands on S_Data_pin[0], making bit 0 the MSB.
    assign S_Data_pin   = data_q;
    assign S_DCLKIO_pin = dclk_q;
    assign S_Clkout_pin = dclk_q;
    assign S_PinMD_pin  = PINMD_VAL;
    assign S_ClkMD_pin  = CLKMD_VAL;
    assign S_Format_pin = format_q;
    assign S_PWRDN_pin  = pwrdn_q;
    assign underrun     = underrun_q;

endmodule
